// File: rtl/bitser_tx_pkg.sv
// Shared types and constants for the bit-serial multi-lane transmitter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Optional feature macro: BITSER_TX_PARITY_EN adds a trailing even-parity bit per frame.
package bitser_tx_pkg;

    localparam int W_DEF     = 8;
    localparam int LANES_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Per-lane datapath commands issued by the top-level FSM.
    typedef struct packed {
        logic load_in;    // shifter <- in_data (frame start from the bus)
        logic load_hold;  // shifter <- holding slot (frame start from hold)
        logic shift;      // shift right one bit
        logic cap_hold;   // holding slot <- in_data
    } lane_ctl_t;

    // Frame length in bit cycles for an operand of width w.
    function automatic int flen(input int w);
`ifdef BITSER_TX_PARITY_EN
        return w + 1;
`else
        return w;
`endif
    endfunction

endpackage

// File: rtl/bitser_tx_if.sv
// Handshake and serial-output bundle of bitser_tx.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready; serial side has no backpressure.
// Ports: in_valid, in_ready, in_data (lane k at [k*W +: W]),
//        ser_out (one bit per lane), ser_frame, ser_active, busy.
interface bitser_tx_if
    import bitser_tx_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LANES = LANES_DEF
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   in_data;
    logic [LANES-1:0]     ser_out;
    logic                 ser_frame;
    logic                 ser_active;
    logic                 busy;

    // Host side: presents operand sets, observes the serial stream.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ser_out,
        input  ser_frame,
        input  ser_active,
        input  busy
    );

    // Transmitter side.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ser_out,
        output ser_frame,
        output ser_active,
        output busy
    );

endinterface

// File: rtl/bitser_tx_lane.sv
// One serial lane: frame shift register, one-entry holding slot, optional parity bit.
// Latency: bit 0 of a loaded frame is on o_bit the cycle after the load edge.
// Backpressure: none locally; the top FSM decides when to load/capture.
// Ports: clk, rst (sync, active-high), i_ctl (load/shift/capture commands),
//        i_data (this lane's operand), o_bit (shifter bit 0, ungated).
// Macro: BITSER_TX_PARITY_EN appends the operand's even parity as the last frame bit.
module bitser_tx_lane
    import bitser_tx_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  lane_ctl_t     i_ctl,
    input  logic [W-1:0]  i_data,
    output logic          o_bit
);

    localparam int FLEN = flen(W);

    logic [FLEN-1:0] r_shift;
    logic [FLEN-1:0] r_hold;
    logic [FLEN-1:0] w_frame;

    // The whole frame, parity included, is built at load time so the
    // parity bit simply falls out of bit 0 after W shifts.
`ifdef BITSER_TX_PARITY_EN
    assign w_frame = {^i_data, i_data};
`else
    assign w_frame = i_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_hold  <= '0;
        end else begin
            if (i_ctl.load_in) begin
                r_shift <= w_frame;
            end else if (i_ctl.load_hold) begin
                r_shift <= r_hold;
            end else if (i_ctl.shift) begin
                r_shift <= r_shift >> 1;
            end
            if (i_ctl.cap_hold) begin
                r_hold <= w_frame;
            end
        end
    end

    assign o_bit = r_shift[0];

endmodule

// File: rtl/bitser_tx.sv
// Bit-serial multi-lane transmitter: LANES parallel W-bit operands out LSB-first, one bit/clock.
// Latency: transfer at edge N -> bit 0 and ser_frame in the cycle after edge N.
// Backpressure: in_ready = !hold_v; a one-entry holding slot gives gap-free back-to-back frames.
// Ports: clk, rst (sync, active-high), bus (bitser_tx_if.slave: in_valid/in_ready/in_data,
//        ser_out, ser_frame, ser_active, busy).
// Macro: BITSER_TX_PARITY_EN extends each frame by one even-parity cycle (FLEN = W+1).
module bitser_tx
    import bitser_tx_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    bitser_tx_if.slave  bus
);

    localparam int            FLEN = flen(W);
    localparam int            CW   = $clog2(FLEN);
    localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_hold_v;
    logic            w_hold_v_nxt;
    lane_ctl_t       w_ctl;
    logic            w_xfer;
    logic [LANES-1:0] w_lane_bit;

    // Forced low during reset so nothing is accepted on the reset edge.
    assign bus.in_ready = !r_hold_v && !rst;
    assign w_xfer       = bus.in_valid && bus.in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hold_v <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hold_v <= w_hold_v_nxt;
        end
    end

    // Next state, counter and lane commands.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hold_v_nxt = r_hold_v;
        w_ctl        = '0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_nxt   = SHIFT;
                    w_cnt_nxt     = '0;
                    w_ctl.load_in = 1'b1;
                end
            end
            SHIFT: begin
                if (r_cnt != LAST) begin
                    w_ctl.shift = 1'b1;
                    w_cnt_nxt   = r_cnt + CW'(1);
                    if (w_xfer) begin
                        w_ctl.cap_hold = 1'b1;
                        w_hold_v_nxt   = 1'b1;
                    end
                end else if (r_hold_v) begin
                    // Last bit: the held set starts the next frame with no gap.
                    // in_ready is low here, so no transfer can coincide.
                    w_ctl.load_hold = 1'b1;
                    w_hold_v_nxt    = 1'b0;
                    w_cnt_nxt       = '0;
                end else if (w_xfer) begin
                    // Last bit with an empty slot: load straight from the bus.
                    w_ctl.load_in = 1'b1;
                    w_cnt_nxt     = '0;
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        bitser_tx_lane #(
            .W (W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_ctl  (w_ctl),
            .i_data (bus.in_data[k*W +: W]),
            .o_bit  (w_lane_bit[k])
        );
    end

    // Outputs. The shifter keeps stale data in IDLE, so lane bits are gated.
    assign bus.ser_active = (r_state == SHIFT);
    assign bus.ser_frame  = (r_state == SHIFT) && (r_cnt == '0);
    assign bus.busy       = (r_state == SHIFT) || r_hold_v;
    assign bus.ser_out    = (r_state == SHIFT) ? w_lane_bit : '0;

endmodule

// File: tb/tb_bitser_tx.sv
// Bench for bitser_tx: scoreboard of expected serial bits plus per-cycle observation log.
// Latency: n/a.
// Backpressure: the driver holds in_valid until in_ready is seen high.
module tb_bitser_tx;
    import bitser_tx_pkg::*;

    localparam int W     = 8;
    localparam int LANES = 4;
    localparam int FLEN  = flen(W);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bitser_tx_if #(.W(W), .LANES(LANES)) bus ();

    bitser_tx #(
        .W     (W),
        .LANES (LANES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [LANES-1:0] so;
        logic             fr;
    } bit_t;

    typedef struct packed {
        logic             act;
        logic             fr;
        logic             rdy;
        logic             bsy;
        logic [LANES-1:0] so;
    } obs_t;

    typedef struct {
        logic [LANES*W-1:0] data;
        int                 gap;
        logic [LANES-1:0]   par;  // per-lane even parity, worked out by hand
    } vec_t;

    bit_t exp_q [$];
    obs_t log_q [$];
    logic rec_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    // Serial pattern for {5A,FF,80,01}, nibble = {lane3,lane2,lane1,lane0} per bit cycle.
    localparam logic [3:0] LIT_SO [8] = '{4'h5, 4'hC, 4'h4, 4'hC, 4'hC, 4'h4, 4'hC, 4'h6};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [LANES-1:0] lane_par(input logic [LANES*W-1:0] d);
        logic [LANES-1:0] p;
        for (int k = 0; k < LANES; k++) p[k] = ^d[k*W +: W];
        return p;
    endfunction

    task automatic push_frame(input logic [LANES*W-1:0] d, input logic [LANES-1:0] par);
        bit_t e;
        for (int i = 0; i < FLEN; i++) begin
            for (int k = 0; k < LANES; k++) e.so[k] = (i < W) ? d[k*W + i] : par[k];
            e.fr = (i == 0);
            exp_q.push_back(e);
        end
    endtask

    // Present one operand set; returns 1 time unit after the accepting edge.
    task automatic send_set(input logic [LANES*W-1:0] d, input logic [LANES-1:0] par);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                push_frame(d, par);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles, required 1");
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (!bus.busy) done = 1'b1;
        end
        @(negedge clk);
        if (!done) begin
            n_total++;
            $display("FAIL idle_timeout: busy stayed 1 for 300 cycles, required 0");
        end
        check("frames_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic log_start();
        log_q.delete();
        rec_en = 1'b1;
    endtask

    task automatic log_stats(output int first, output int act_cnt, output int contig,
                             output int frames, output int second_off, output int rdy_low);
        bit run;
        first = -1; act_cnt = 0; contig = 0; frames = 0; second_off = -1; rdy_low = 0;
        run = 1'b1;
        foreach (log_q[i]) begin
            if (log_q[i].act) begin
                act_cnt++;
                if (first < 0) first = i;
                if (!log_q[i].rdy) rdy_low++;
            end
            if (first >= 0 && run) begin
                if (log_q[i].act) contig++;
                else run = 1'b0;
            end
            if (log_q[i].fr) begin
                frames++;
                if (frames == 2) second_off = i - first;
            end
        end
    endtask

    // Monitor: log every cycle on request; score every active bit cycle.
    always @(negedge clk) begin : mon
        bit_t e;
        if (rec_en) log_q.push_back({bus.ser_active, bus.ser_frame, bus.in_ready, bus.busy, bus.ser_out});
        if (!rst && bus.ser_active) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_bit: ser_active=1 with no frame outstanding, required ser_active=0");
            end else begin
                e = exp_q.pop_front();
                check("ser_bits", {bus.ser_out, bus.ser_frame}, {e.so, e.fr});
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t vecs [6];
        int f, ac, ct, nf, so2, rl;
        logic [FLEN-1:0] s0;

        vecs[0] = '{32'h5AFF8001, 0, 4'b0011};
        vecs[1] = '{32'h00000000, 0, 4'b0000};
        vecs[2] = '{32'hFFFFFFFF, 3, 4'b0000};
        vecs[3] = '{32'h03070F1F, 0, 4'b0101};
        vecs[4] = '{32'hA5C33C80, 1, 4'b0001};
        vecs[5] = '{32'h12345678, 0, 4'b0100};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_ready_during_rst", bus.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ser_out", bus.ser_out, 0);
        check("rst_ser_frame", bus.ser_frame, 0);
        check("rst_ser_active", bus.ser_active, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Single set with hand-written serial pattern.
        log_start();
        send_set(32'h5AFF8001, 4'b0011);
        wait_idle();
        rec_en = 1'b0;
        log_stats(f, ac, ct, nf, so2, rl);
        check("single_active_len", ac, FLEN);
        check("single_frames", nf, 1);
        check("single_busy_after", log_q[log_q.size()-1].bsy, 0);
        if (f >= 0 && f + 8 <= log_q.size()) begin
            for (int i = 0; i < 8; i++) check("single_pattern", log_q[f+i].so, LIT_SO[i]);
        end else begin
            n_total++;
            $display("FAIL single_start: no active frame seen, required one");
        end

        // Back-to-back through the holding slot.
        log_start();
        send_set(32'h11223344, lane_par(32'h11223344));
        send_set(32'hC0FFEE01, lane_par(32'hC0FFEE01));
        wait_idle();
        rec_en = 1'b0;
        log_stats(f, ac, ct, nf, so2, rl);
        check("b2b_contig", ct, 2*FLEN);
        check("b2b_frames", nf, 2);
        check("b2b_second_frame_off", so2, FLEN);
        check("b2b_ready_low", rl, FLEN-1);

        // New set arriving on the last-bit edge loads directly, slot untouched.
        log_start();
        send_set(32'h0F0F0F0F, lane_par(32'h0F0F0F0F));
        tick(FLEN-1);
        send_set(32'h80402010, lane_par(32'h80402010));
        wait_idle();
        rec_en = 1'b0;
        log_stats(f, ac, ct, nf, so2, rl);
        check("direct_contig", ct, 2*FLEN);
        check("direct_second_frame_off", so2, FLEN);
        check("direct_ready_low", rl, 0);

        // in_valid held through a long in_ready=0 stall: one transfer per set.
        log_start();
        send_set(32'hDEADBEEF, lane_par(32'hDEADBEEF));
        send_set(32'h01020304, lane_par(32'h01020304));
        send_set(32'hF00DCAFE, lane_par(32'hF00DCAFE));
        wait_idle();
        rec_en = 1'b0;
        log_stats(f, ac, ct, nf, so2, rl);
        check("stall_frames", nf, 3);
        check("stall_contig", ct, 3*FLEN);
        check("stall_ready_low", rl, 2*(FLEN-1));

        // Reset during bit 3 with the holding slot occupied.
        send_set(32'hAAAA5555, lane_par(32'hAAAA5555));
        send_set(32'h77777777, lane_par(32'h77777777));
        tick(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_ser_out", bus.ser_out, 0);
        check("midrst_ser_frame", bus.ser_frame, 0);
        check("midrst_ser_active", bus.ser_active, 0);
        check("midrst_busy", bus.busy, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        log_start();
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 1);
        tick(3*FLEN);
        rec_en = 1'b0;
        log_stats(f, ac, ct, nf, so2, rl);
        check("midrst_no_stale", ac, 0);

        // Table of operand sets with assorted idle gaps.
        foreach (vecs[i]) begin
            tick(vecs[i].gap);
            send_set(vecs[i].data, vecs[i].par);
        end
        wait_idle();

`ifdef BITSER_TX_PARITY_EN
        // Lane0 = 0x07 (odd, parity 1), lane1 = 0x03 (even, parity 0).
        log_start();
        send_set(32'h00000307, 4'b0001);
        send_set(32'h00000307, 4'b0001);
        wait_idle();
        rec_en = 1'b0;
        log_stats(f, ac, ct, nf, so2, rl);
        check("par_period", so2, 9);
        if (f >= 0 && f + FLEN <= log_q.size()) begin
            for (int i = 0; i < FLEN; i++) s0[i] = log_q[f+i].so[0];
            check("par_lane0_stream", s0, 9'h107);
            check("par_lane1_bit", log_q[f+8].so[1], 0);
        end else begin
            n_total++;
            $display("FAIL par_start: no active frame seen, required one");
        end
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
